// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - board/SoC-side signal bundle of the reset sequencer
// Watchdog signals exist only when RST_SEQ_WDT_EN is defined.
interface rst_seq_if;
   logic       btn_n;
   logic       locked;
   logic       sys_resetn;
   logic       phy_reset_n;
   logic [1:0] state;
`ifdef RST_SEQ_WDT_EN
   logic       wdt_kick;
   logic       wdt_trip;
`endif

   modport master (
      input  btn_n,
      input  locked,
`ifdef RST_SEQ_WDT_EN
      input  wdt_kick,
      output wdt_trip,
`endif
      output sys_resetn,
      output phy_reset_n,
      output state
   );

   modport slave (
      output btn_n,
      output locked,
`ifdef RST_SEQ_WDT_EN
      output wdt_kick,
      input  wdt_trip,
`endif
      input  sys_resetn,
      input  phy_reset_n,
      input  state
   );
endinterface

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - power-up/recovery reset sequencer: PHY reset, settle, then SoC reset release
// Optional watchdog in S_RUN is enabled by defining RST_SEQ_WDT_EN.
module rst_seq #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd1250000,
   parameter int unsigned PHY_HOLD_CYCLES = 32'd1250000,
   parameter int unsigned PHY_WAIT_CYCLES = 32'd6250000,
   parameter int unsigned WDT_CYCLES      = 32'd125000000
) (
   input  logic      clk,
   input  logic      resetn,
   rst_seq_if.master bus
);
   localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW_MAX   = (PHY_HOLD_CYCLES > PHY_WAIT_CYCLES) ? PHY_HOLD_CYCLES
                                                                          : PHY_WAIT_CYCLES;
   localparam int unsigned SEQ_MAX  = (HW_MAX > WDT_CYCLES) ? HW_MAX : WDT_CYCLES;
   localparam int unsigned SEQ_W    = $clog2(SEQ_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(PHY_HOLD_CYCLES - 1);
   localparam logic [SEQ_W-1:0] WAIT_LAST = SEQ_W'(PHY_WAIT_CYCLES - 1);
`ifdef RST_SEQ_WDT_EN
   localparam logic [SEQ_W-1:0] WDT_LAST  = SEQ_W'(WDT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_PHY_RST = 2'd1,
      S_SETTLE  = 2'd2,
      S_RUN     = 2'd3
   } state_t;

   logic [1:0]       btn_sync;
   logic [1:0]       lock_sync;
   logic             btn_s;
   logic             lock_s;
   logic             btn_db;
   logic [DB_W-1:0]  db_cnt;
   state_t           cur_st;
   state_t           nxt_st;
   logic [SEQ_W-1:0] seq_cnt;
   logic             seq_clr;
   logic             seq_inc;
   logic             sys_resetn_q;
   logic             phy_reset_n_q;
`ifdef RST_SEQ_WDT_EN
   logic             wdt_fire;
   logic             wdt_trip_q;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         btn_sync  <= 2'b00;
         lock_sync <= 2'b00;
      end else begin
         btn_sync  <= {btn_sync[0], bus.btn_n};
         lock_sync <= {lock_sync[0], bus.locked};
      end
   end

   assign btn_s  = btn_sync[1];
   assign lock_s = lock_sync[1];

   // A new level must persist DEBOUNCE_CYCLES consecutive cycles before it is accepted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         btn_db <= 1'b0;
         db_cnt <= '0;
      end else if (btn_s == btn_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         btn_db <= btn_s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   always_comb begin
      nxt_st  = cur_st;
      seq_clr = 1'b0;
      seq_inc = 1'b0;
`ifdef RST_SEQ_WDT_EN
      wdt_fire = 1'b0;
`endif
      case (cur_st)
         S_WAIT: begin
            if (btn_db && lock_s)
               nxt_st = S_PHY_RST;
         end
         S_PHY_RST: begin
            if (seq_cnt == HOLD_LAST)
               nxt_st = S_SETTLE;
            else
               seq_inc = 1'b1;
         end
         S_SETTLE: begin
            if (seq_cnt == WAIT_LAST)
               nxt_st = S_RUN;
            else
               seq_inc = 1'b1;
         end
         S_RUN: begin
`ifdef RST_SEQ_WDT_EN
            // Kicks only matter while running; a kick on the timeout cycle wins.
            if (bus.wdt_kick) begin
               seq_clr = 1'b1;
            end else if (seq_cnt == WDT_LAST) begin
               nxt_st   = S_WAIT;
               wdt_fire = 1'b1;
            end else begin
               seq_inc = 1'b1;
            end
`else
            nxt_st = S_RUN;
`endif
         end
         default: nxt_st = S_WAIT;
      endcase

      if (cur_st != S_WAIT && (!btn_db || !lock_s)) begin
         nxt_st = S_WAIT;
`ifdef RST_SEQ_WDT_EN
         wdt_fire = 1'b0;
`endif
      end

      if (nxt_st != cur_st) begin
         seq_clr = 1'b1;
         seq_inc = 1'b0;
      end
   end

   // Outputs decode the next state so they change on the same edge as the state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cur_st        <= S_WAIT;
         seq_cnt       <= '0;
         sys_resetn_q  <= 1'b0;
         phy_reset_n_q <= 1'b0;
      end else begin
         cur_st <= nxt_st;
         if (seq_clr)
            seq_cnt <= '0;
         else if (seq_inc)
            seq_cnt <= seq_cnt + SEQ_W'(1);
         sys_resetn_q  <= (nxt_st == S_RUN);
         phy_reset_n_q <= (nxt_st == S_SETTLE) || (nxt_st == S_RUN);
      end
   end

`ifdef RST_SEQ_WDT_EN
   always_ff @(posedge clk) begin
      if (!resetn)
         wdt_trip_q <= 1'b0;
      else if (wdt_fire)
         wdt_trip_q <= 1'b1;
   end

   assign bus.wdt_trip = wdt_trip_q;
`endif

   assign bus.sys_resetn  = sys_resetn_q;
   assign bus.phy_reset_n = phy_reset_n_q;
   assign bus.state       = cur_st;
endmodule
